gpdma_ctrl: RTL and testbench

General-purpose DMA controller for the console bus: the initiator side of the B-bus that WRAM, PPU and APU ports respond to. It holds the eight channel register sets ($43x0–$43x6) and MDMAEN ($420B). On a start it halts the CPU and moves bytes between an A-bus address and a B-bus register ($21xx), one channel at a time. It drives A-bus and B-bus strobes directly. The existing bus decoder turns `b_addr` plus `b_read`/`b_write` into `b_op`.

---
 rtl/bus_pkg.sv | 37 +++
 rtl/dma_chan_regs.sv | 94 +++++++++
 rtl/gpdma_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_gpdma_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared B-bus / DMA definitions.
//   dma_state_t     - DMA engine states
//   dma_b_offset()  - B-bus register offset for a transfer mode and byte index
//   a_bus_blocked() - true when an A-bus address points at the on-chip
//                     register ranges that DMA must not touch
//   ADDR_MDMAEN, ADDR_DMA_BASE - CPU register addresses
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SELECT = 2'd1,
      READ   = 2'd2,
      WRITE  = 2'd3
   } dma_state_t;

   localparam logic [15:0] ADDR_MDMAEN   = 16'h420B;
   localparam logic [15:0] ADDR_DMA_BASE = 16'h4300;

   function automatic logic [1:0] dma_b_offset(input logic [2:0] mode,
                                               input logic [1:0] index);
      logic [1:0] off;
      case (mode)
         3'd1, 3'd5: off = {1'b0, index[0]};   // 0,1,0,1
         3'd3, 3'd7: off = {1'b0, index[1]};   // 0,0,1,1
         3'd4:       off = index;              // 0,1,2,3
         default:    off = 2'd0;               // modes 0, 2, 6
      endcase
      return off;
   endfunction

   // Banks $00-$3F and $80-$BF (bit 22 clear) mirror the system area, where
   // $21xx is the B-bus and $40xx-$43xx are CPU I/O registers.
   function automatic logic a_bus_blocked(input logic [23:0] addr);
      return !addr[22] && ((addr[15:8] == 8'h21) || (addr[15:10] == 6'b010000));
   endfunction

endpackage

// File: rtl/dma_chan_regs.sv
// dma_chan_regs: eight DMA channel register sets ($43n0-$43n6).
//   cpu_we_i/cpu_ch_i/cpu_reg_i/cpu_wdata_i - CPU write port
//   rd_ch_i/rd_reg_i/rd_data_o              - combinational CPU read port
//   sel_ch_i                                - channel the engine works on
//   sel_*_o                                 - decoded fields of that channel
//   wb_en_i/wb_a1t_i/wb_das_i               - per-byte progress writeback
module dma_chan_regs
   import bus_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_we_i,
   input  logic [2:0]  cpu_ch_i,
   input  logic [2:0]  cpu_reg_i,
   input  logic [7:0]  cpu_wdata_i,
   input  logic [2:0]  rd_ch_i,
   input  logic [2:0]  rd_reg_i,
   output logic [7:0]  rd_data_o,
   input  logic [2:0]  sel_ch_i,
   output logic        sel_dir_o,
   output logic [1:0]  sel_step_o,
   output logic [2:0]  sel_mode_o,
   output logic [7:0]  sel_bbad_o,
   output logic [23:0] sel_a1t_o,
   output logic [15:0] sel_das_o,
   input  logic        wb_en_i,
   input  logic [15:0] wb_a1t_i,
   input  logic [15:0] wb_das_i
);

   logic [7:0] dmap_q [8];
   logic [7:0] bbad_q [8];
   logic [7:0] a1tl_q [8];
   logic [7:0] a1th_q [8];
   logic [7:0] a1tb_q [8];
   logic [7:0] dasl_q [8];
   logic [7:0] dash_q [8];

   // CPU writes only happen while the engine is idle and writeback only while
   // it runs, so the two ports never collide.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            dmap_q[i] <= '0;
            bbad_q[i] <= '0;
            a1tl_q[i] <= '0;
            a1th_q[i] <= '0;
            a1tb_q[i] <= '0;
            dasl_q[i] <= '0;
            dash_q[i] <= '0;
         end
      end else begin
         if (cpu_we_i) begin
            case (cpu_reg_i)
               3'd0:    dmap_q[cpu_ch_i] <= cpu_wdata_i;
               3'd1:    bbad_q[cpu_ch_i] <= cpu_wdata_i;
               3'd2:    a1tl_q[cpu_ch_i] <= cpu_wdata_i;
               3'd3:    a1th_q[cpu_ch_i] <= cpu_wdata_i;
               3'd4:    a1tb_q[cpu_ch_i] <= cpu_wdata_i;
               3'd5:    dasl_q[cpu_ch_i] <= cpu_wdata_i;
               3'd6:    dash_q[cpu_ch_i] <= cpu_wdata_i;
               default: ;
            endcase
         end
         if (wb_en_i) begin
            a1tl_q[sel_ch_i] <= wb_a1t_i[7:0];
            a1th_q[sel_ch_i] <= wb_a1t_i[15:8];
            dasl_q[sel_ch_i] <= wb_das_i[7:0];
            dash_q[sel_ch_i] <= wb_das_i[15:8];
         end
      end
   end

   always_comb begin
      case (rd_reg_i)
         3'd0:    rd_data_o = dmap_q[rd_ch_i];
         3'd1:    rd_data_o = bbad_q[rd_ch_i];
         3'd2:    rd_data_o = a1tl_q[rd_ch_i];
         3'd3:    rd_data_o = a1th_q[rd_ch_i];
         3'd4:    rd_data_o = a1tb_q[rd_ch_i];
         3'd5:    rd_data_o = dasl_q[rd_ch_i];
         3'd6:    rd_data_o = dash_q[rd_ch_i];
         default: rd_data_o = 8'h00;
      endcase
   end

   assign sel_dir_o  = dmap_q[sel_ch_i][7];
   assign sel_step_o = dmap_q[sel_ch_i][4:3];
   assign sel_mode_o = dmap_q[sel_ch_i][2:0];
   assign sel_bbad_o = bbad_q[sel_ch_i];
   assign sel_a1t_o  = {a1tb_q[sel_ch_i], a1th_q[sel_ch_i], a1tl_q[sel_ch_i]};
   assign sel_das_o  = {dash_q[sel_ch_i], dasl_q[sel_ch_i]};

endmodule

// File: rtl/gpdma_ctrl.sv
// gpdma_ctrl: general-purpose DMA engine, B-bus initiator.
//   clk/reset/cpu_en          - clock, sync active-high reset, bus step enable
//   io_addr/io_write/io_wdata - CPU register writes ($43n0-$43n6, $420B)
//   io_rdata                  - combinational channel register readback
//   dma_active                - CPU halt request while transferring
//   a_addr/a_read/a_write     - A-bus address and strobes
//   b_addr/b_read/b_write     - B-bus register offset and strobes
//   bus_rdata/bus_wdata       - returned source byte / latched transfer byte
module gpdma_ctrl
   import bus_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_en,
   input  logic [15:0] io_addr,
   input  logic        io_write,
   input  logic [7:0]  io_wdata,
   output logic [7:0]  io_rdata,
   output logic        dma_active,
   output logic [23:0] a_addr,
   output logic        a_read,
   output logic        a_write,
   output logic [7:0]  b_addr,
   output logic        b_read,
   output logic        b_write,
   input  logic [7:0]  bus_rdata,
   output logic [7:0]  bus_wdata
);

   dma_state_t  state_q, state_d;
   logic [7:0]  mdmaen_q, mdmaen_d;
   logic [2:0]  chan_q, chan_d;
   logic [1:0]  idx_q, idx_d;
   logic [23:0] a_addr_q, a_addr_d;
   logic [7:0]  b_addr_q, b_addr_d;
   logic [7:0]  bus_wdata_q, bus_wdata_d;
   logic        a_read_q, a_read_d, a_write_q, a_write_d;
   logic        b_read_q, b_read_d, b_write_q, b_write_d;

   logic [2:0]  first_ch, sel_ch;
   logic        sel_dir;
   logic [1:0]  sel_step;
   logic [2:0]  sel_mode;
   logic [7:0]  sel_bbad;
   logic [23:0] sel_a1t;
   logic [15:0] sel_das;
   logic [15:0] a1t_step, a1t_next;
   logic        load_next, wb_en, last_byte;
   logic        is_chan_reg, cpu_we, start;
   logic [7:0]  reg_rdata;

   // CPU decode: $4300-$437F with register index 0..6 inside each channel.
   assign is_chan_reg = (io_addr[15:8] == ADDR_DMA_BASE[15:8]) && !io_addr[7]
                        && !io_addr[3] && (io_addr[2:0] != 3'd7);
   assign cpu_we      = cpu_en && io_write && (state_q == IDLE) && is_chan_reg;
   assign start       = cpu_en && io_write && (state_q == IDLE)
                        && (io_addr == ADDR_MDMAEN) && (io_wdata != 8'h00);
   assign io_rdata    = is_chan_reg ? reg_rdata : 8'h00;

   // Lowest pending channel is serviced first.
   always_comb begin
      first_ch = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (mdmaen_q[i]) first_ch = 3'(i);
      end
   end

   assign sel_ch = (state_q == SELECT) ? first_ch : chan_q;

   dma_chan_regs u_regs (
      .clk         (clk),
      .reset       (reset),
      .cpu_we_i    (cpu_we),
      .cpu_ch_i    (io_addr[6:4]),
      .cpu_reg_i   (io_addr[2:0]),
      .cpu_wdata_i (io_wdata),
      .rd_ch_i     (io_addr[6:4]),
      .rd_reg_i    (io_addr[2:0]),
      .rd_data_o   (reg_rdata),
      .sel_ch_i    (sel_ch),
      .sel_dir_o   (sel_dir),
      .sel_step_o  (sel_step),
      .sel_mode_o  (sel_mode),
      .sel_bbad_o  (sel_bbad),
      .sel_a1t_o   (sel_a1t),
      .sel_das_o   (sel_das),
      .wb_en_i     (wb_en && cpu_en),
      .wb_a1t_i    (a1t_step),
      .wb_das_i    (sel_das - 16'd1)
   );

   // Stepping stays inside the 16-bit offset; the bank is never carried into.
   always_comb begin
      if (sel_step[0])      a1t_step = sel_a1t[15:0];
      else if (sel_step[1]) a1t_step = sel_a1t[15:0] - 16'd1;
      else                  a1t_step = sel_a1t[15:0] + 16'd1;
   end

   // DAS of 0 decrements to $FFFF, which gives the 65536-byte case for free.
   assign last_byte = (sel_das == 16'd1);

   // State register
   always_ff @(posedge clk) begin
      if (reset)       state_q <= IDLE;
      else if (cpu_en) state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SELECT;
         SELECT:  state_d = (mdmaen_q != 8'h00) ? READ : IDLE;
         READ:    state_d = WRITE;
         WRITE:   state_d = last_byte ? SELECT : READ;
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath next values. Strobes are computed for the state being
   // entered so the registered strobe lines up with that state.
   always_comb begin
      mdmaen_d    = mdmaen_q;
      chan_d      = chan_q;
      idx_d       = idx_q;
      a_addr_d    = a_addr_q;
      b_addr_d    = b_addr_q;
      bus_wdata_d = bus_wdata_q;
      a_read_d    = 1'b0;
      a_write_d   = 1'b0;
      b_read_d    = 1'b0;
      b_write_d   = 1'b0;
      load_next   = 1'b0;
      wb_en       = 1'b0;
      a1t_next    = sel_a1t[15:0];
      case (state_q)
         IDLE: begin
            if (start) mdmaen_d = io_wdata;
         end
         SELECT: begin
            if (mdmaen_q != 8'h00) begin
               chan_d    = first_ch;
               idx_d     = 2'd0;
               load_next = 1'b1;
            end
         end
         READ: begin
            // A blocked A-bus source was never strobed; substitute zero.
            if (!sel_dir && a_bus_blocked(a_addr_q)) bus_wdata_d = 8'h00;
            else                                     bus_wdata_d = bus_rdata;
            b_write_d = !sel_dir;
            a_write_d = sel_dir && !a_bus_blocked(a_addr_q);
         end
         WRITE: begin
            wb_en = 1'b1;
            if (last_byte) begin
               mdmaen_d[chan_q] = 1'b0;
            end else begin
               idx_d     = idx_q + 2'd1;
               a1t_next  = a1t_step;
               load_next = 1'b1;
            end
         end
         default: ;
      endcase
      if (load_next) begin
         a_addr_d = {sel_a1t[23:16], a1t_next};
         b_addr_d = sel_bbad + {6'd0, dma_b_offset(sel_mode, idx_d)};
         a_read_d = !sel_dir && !a_bus_blocked(a_addr_d);
         b_read_d = sel_dir;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mdmaen_q    <= '0;
         chan_q      <= '0;
         idx_q       <= '0;
         a_addr_q    <= '0;
         b_addr_q    <= '0;
         bus_wdata_q <= '0;
         a_read_q    <= 1'b0;
         a_write_q   <= 1'b0;
         b_read_q    <= 1'b0;
         b_write_q   <= 1'b0;
      end else if (cpu_en) begin
         mdmaen_q    <= mdmaen_d;
         chan_q      <= chan_d;
         idx_q       <= idx_d;
         a_addr_q    <= a_addr_d;
         b_addr_q    <= b_addr_d;
         bus_wdata_q <= bus_wdata_d;
         a_read_q    <= a_read_d;
         a_write_q   <= a_write_d;
         b_read_q    <= b_read_d;
         b_write_q   <= b_write_d;
      end
   end

   // Strobes are masked between steps so a stalled bus never sees them.
   assign a_read     = a_read_q  && cpu_en;
   assign a_write    = a_write_q && cpu_en;
   assign b_read     = b_read_q  && cpu_en;
   assign b_write    = b_write_q && cpu_en;
   assign a_addr     = a_addr_q;
   assign b_addr     = b_addr_q;
   assign bus_wdata  = bus_wdata_q;
   assign dma_active = (state_q != IDLE);

endmodule

// File: tb/tb_gpdma_ctrl.sv
// tb_gpdma_ctrl: directed bench for gpdma_ctrl with a combinational
// A-bus / B-bus source model and per-scenario tasks.
module tb_gpdma_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_en;
   logic [15:0] io_addr;
   logic        io_write;
   logic [7:0]  io_wdata;
   logic [7:0]  io_rdata;
   logic        dma_active;
   logic [23:0] a_addr;
   logic        a_read, a_write;
   logic [7:0]  b_addr;
   logic        b_read, b_write;
   logic [7:0]  bus_rdata;
   logic [7:0]  bus_wdata;

   int total = 0;
   int bad   = 0;

   logic [23:0] rd_a [16];
   logic [7:0]  rd_b [16];
   logic        rd_isa [16];
   int          rd_n;
   logic [23:0] wr_a [16];
   logic [7:0]  wr_b [16];
   logic [7:0]  wr_d [16];
   logic        wr_isa [16];
   int          wr_n;

   gpdma_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_en     (cpu_en),
      .io_addr    (io_addr),
      .io_write   (io_write),
      .io_wdata   (io_wdata),
      .io_rdata   (io_rdata),
      .dma_active (dma_active),
      .a_addr     (a_addr),
      .a_read     (a_read),
      .a_write    (a_write),
      .b_addr     (b_addr),
      .b_read     (b_read),
      .b_write    (b_write),
      .bus_rdata  (bus_rdata),
      .bus_wdata  (bus_wdata)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] a_src(input logic [23:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] b_src(input logic [7:0] b);
      return b ^ 8'hC3;
   endfunction

   // Addressed source drives data while its read strobe is up; 8'hEE otherwise.
   always_comb begin
      if (a_read)      bus_rdata = a_src(a_addr);
      else if (b_read) bus_rdata = b_src(b_addr);
      else             bus_rdata = 8'hEE;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
      io_addr  = a;
      io_wdata = d;
      io_write = 1'b1;
      tick();
      io_write = 1'b0;
   endtask

   task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d);
      io_addr = a;
      #1;
      d = io_rdata;
   endtask

   task automatic setup_chan(input int ch, input logic [7:0] dmap, input logic [7:0] bbad,
                             input logic [23:0] a1t, input logic [15:0] das);
      logic [15:0] base;
      base = 16'h4300 + 16'(ch * 16);
      cpu_wr(base + 16'd0, dmap);
      cpu_wr(base + 16'd1, bbad);
      cpu_wr(base + 16'd2, a1t[7:0]);
      cpu_wr(base + 16'd3, a1t[15:8]);
      cpu_wr(base + 16'd4, a1t[23:16]);
      cpu_wr(base + 16'd5, das[7:0]);
      cpu_wr(base + 16'd6, das[15:8]);
   endtask

   // Counts active steps and logs every strobe, for at most max steps.
   task automatic run_xfer(input int max, output int steps, output logic done);
      steps = 0;
      done  = 1'b0;
      rd_n  = 0;
      wr_n  = 0;
      for (int c = 0; c < max; c++) begin
         if (!dma_active) begin
            done = 1'b1;
            break;
         end
         steps++;
         if ((a_read || b_read) && rd_n < 16) begin
            rd_a[rd_n] = a_addr; rd_b[rd_n] = b_addr; rd_isa[rd_n] = a_read;
            rd_n++;
         end
         if ((a_write || b_write) && wr_n < 16) begin
            wr_a[wr_n] = a_addr; wr_b[wr_n] = b_addr; wr_d[wr_n] = bus_wdata;
            wr_isa[wr_n] = a_write;
            wr_n++;
         end
         tick();
      end
      if (!done && !dma_active) done = 1'b1;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      reset = 1'b1; cpu_en = 1'b1; io_write = 1'b0; io_addr = '0; io_wdata = '0;
      tick(); tick(); tick();
      reset = 1'b0;
      total++; if (dma_active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", dma_active); end
      total++; if ({a_read, a_write, b_read, b_write} !== 4'b0) begin bad++; $display("FAIL reset_strobes got=%b exp=0000", {a_read, a_write, b_read, b_write}); end
      total++; if (a_addr !== 24'h0) begin bad++; $display("FAIL reset_a_addr got=%h exp=000000", a_addr); end
      total++; if (b_addr !== 8'h0) begin bad++; $display("FAIL reset_b_addr got=%h exp=00", b_addr); end
      total++; if (bus_wdata !== 8'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=00", bus_wdata); end
      for (int r = 0; r < 7; r++) begin
         cpu_rd(16'h4370 + 16'(r), d);
         total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_reg r=%0d got=%h exp=00", r, d); end
      end
   endtask

   task automatic test_regs();
      logic [7:0] d;
      for (int r = 0; r < 7; r++) cpu_wr(16'h4350 + 16'(r), 8'h11 + 8'(r));
      for (int r = 0; r < 7; r++) begin
         cpu_rd(16'h4350 + 16'(r), d);
         total++; if (d !== 8'h11 + 8'(r)) begin bad++; $display("FAIL regs_rb r=%0d got=%h exp=%h", r, d, 8'h11 + 8'(r)); end
      end
      cpu_rd(16'h4357, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL regs_unmapped got=%h exp=00", d); end
      cpu_wr(16'h420B, 8'h00);
      total++; if (dma_active !== 1'b0) begin bad++; $display("FAIL regs_zero_start got=%b exp=0", dma_active); end
   endtask

   task automatic test_basic();
      int steps; logic done; logic [7:0] d;
      setup_chan(0, 8'h00, 8'h80, 24'h7E1000, 16'd3);
      cpu_wr(16'h420B, 8'h01);
      run_xfer(40, steps, done);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_timeout got=%b exp=1", done); end
      total++; if (steps != 8) begin bad++; $display("FAIL basic_active got=%0d exp=8", steps); end
      total++; if (wr_n != 3 || rd_n != 3) begin bad++; $display("FAIL basic_counts got=%0d/%0d exp=3/3", wr_n, rd_n); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (wr_isa[i] !== 1'b0 || wr_b[i] !== 8'h80 || wr_d[i] !== a_src(24'h7E1000 + 24'(i))
             || rd_isa[i] !== 1'b1 || rd_a[i] !== 24'h7E1000 + 24'(i)) begin
            bad++; $display("FAIL basic_byte%0d got=b%h d%h a%h exp=b80 d%h a%h", i, wr_b[i], wr_d[i], rd_a[i],
                            a_src(24'h7E1000 + 24'(i)), 24'h7E1000 + 24'(i));
         end
      end
      cpu_rd(16'h4305, d); total++; if (d !== 8'h00) begin bad++; $display("FAIL basic_dasl got=%h exp=00", d); end
      cpu_rd(16'h4306, d); total++; if (d !== 8'h00) begin bad++; $display("FAIL basic_dash got=%h exp=00", d); end
      cpu_rd(16'h4302, d); total++; if (d !== 8'h03) begin bad++; $display("FAIL basic_a1tl got=%h exp=03", d); end
      cpu_rd(16'h4303, d); total++; if (d !== 8'h10) begin bad++; $display("FAIL basic_a1th got=%h exp=10", d); end
      cpu_rd(16'h4304, d); total++; if (d !== 8'h7E) begin bad++; $display("FAIL basic_a1tb got=%h exp=7E", d); end
   endtask

   task automatic test_mode1();
      int steps; logic done;
      logic [7:0] exp_b [4];
      exp_b = '{8'h18, 8'h19, 8'h18, 8'h19};
      setup_chan(2, 8'h01, 8'h18, 24'h7E3000, 16'd4);
      cpu_wr(16'h420B, 8'h04);
      run_xfer(40, steps, done);
      total++; if (!done || steps != 10 || wr_n != 4) begin bad++; $display("FAIL mode1_len got=%0d/%0d exp=10/4", steps, wr_n); end
      for (int i = 0; i < 4; i++) begin
         total++; if (wr_b[i] !== exp_b[i]) begin bad++; $display("FAIL mode1_baddr%0d got=%h exp=%h", i, wr_b[i], exp_b[i]); end
      end
   endtask

   task automatic test_mode4_dec();
      int steps; logic done; logic [7:0] d;
      logic [7:0]  exp_b [5];
      logic [23:0] exp_a [5];
      exp_b = '{8'h34, 8'h35, 8'h36, 8'h37, 8'h34};
      exp_a = '{24'h000001, 24'h000000, 24'h00FFFF, 24'h00FFFE, 24'h00FFFD};
      // bits 4:3 = 10 (decrement), mode 4
      setup_chan(0, 8'h14, 8'h34, 24'h000001, 16'd5);
      cpu_wr(16'h420B, 8'h01);
      run_xfer(40, steps, done);
      total++; if (!done || wr_n != 5 || rd_n != 5) begin bad++; $display("FAIL mode4_len got=%0d/%0d exp=5/5", wr_n, rd_n); end
      for (int i = 0; i < 5; i++) begin
         total++; if (wr_b[i] !== exp_b[i]) begin bad++; $display("FAIL mode4_baddr%0d got=%h exp=%h", i, wr_b[i], exp_b[i]); end
         total++; if (rd_a[i] !== exp_a[i] || rd_isa[i] !== 1'b1) begin bad++; $display("FAIL mode4_aaddr%0d got=%h exp=%h", i, rd_a[i], exp_a[i]); end
      end
      cpu_rd(16'h4302, d); total++; if (d !== 8'hFC) begin bad++; $display("FAIL mode4_a1tl got=%h exp=FC", d); end
      cpu_rd(16'h4304, d); total++; if (d !== 8'h00) begin bad++; $display("FAIL mode4_bank got=%h exp=00", d); end
   endtask

   task automatic test_multi();
      int steps; logic done;
      logic [7:0] exp_b [3];
      logic [7:0] exp_d [3];
      setup_chan(0, 8'h00, 8'h10, 24'h7E4000, 16'd1);
      setup_chan(3, 8'h00, 8'h20, 24'h7E5000, 16'd2);
      exp_b = '{8'h10, 8'h20, 8'h20};
      exp_d = '{a_src(24'h7E4000), a_src(24'h7E5000), a_src(24'h7E5001)};
      cpu_wr(16'h420B, 8'h09);
      run_xfer(40, steps, done);
      total++; if (!done || steps != 9) begin bad++; $display("FAIL multi_active got=%0d exp=9", steps); end
      total++; if (wr_n != 3) begin bad++; $display("FAIL multi_count got=%0d exp=3", wr_n); end
      for (int i = 0; i < 3; i++) begin
         total++; if (wr_b[i] !== exp_b[i] || wr_d[i] !== exp_d[i]) begin
            bad++; $display("FAIL multi_byte%0d got=b%h d%h exp=b%h d%h", i, wr_b[i], wr_d[i], exp_b[i], exp_d[i]);
         end
      end
   endtask

   task automatic test_b_to_a();
      int steps; logic done;
      setup_chan(1, 8'h80, 8'h40, 24'h7E2000, 16'd2);
      cpu_wr(16'h420B, 8'h02);
      run_xfer(40, steps, done);
      total++; if (!done || steps != 6 || rd_n != 2 || wr_n != 2) begin
         bad++; $display("FAIL btoa_len got=%0d/%0d/%0d exp=6/2/2", steps, rd_n, wr_n);
      end
      for (int i = 0; i < 2; i++) begin
         total++; if (rd_isa[i] !== 1'b0 || rd_b[i] !== 8'h40) begin bad++; $display("FAIL btoa_rd%0d got=isa%b b%h exp=isa0 b40", i, rd_isa[i], rd_b[i]); end
         total++; if (wr_isa[i] !== 1'b1 || wr_a[i] !== 24'h7E2000 + 24'(i) || wr_d[i] !== b_src(8'h40)) begin
            bad++; $display("FAIL btoa_wr%0d got=a%h d%h exp=a%h d%h", i, wr_a[i], wr_d[i], 24'h7E2000 + 24'(i), b_src(8'h40));
         end
      end
   endtask

   task automatic test_suppress_wrap();
      int steps; logic done; logic [7:0] d;
      setup_chan(0, 8'h00, 8'h80, 24'h002180, 16'd0);
      cpu_wr(16'h420B, 8'h01);
      run_xfer(7, steps, done);
      total++; if (done !== 1'b0 || dma_active !== 1'b1) begin bad++; $display("FAIL supp_running got=%b exp=1", dma_active); end
      total++; if (rd_n != 0) begin bad++; $display("FAIL supp_no_aread got=%0d exp=0", rd_n); end
      total++; if (wr_n != 3) begin bad++; $display("FAIL supp_count got=%0d exp=3", wr_n); end
      for (int i = 0; i < 3; i++) begin
         total++; if (wr_d[i] !== 8'h00 || wr_b[i] !== 8'h80) begin bad++; $display("FAIL supp_byte%0d got=d%h b%h exp=d00 b80", i, wr_d[i], wr_b[i]); end
      end
      cpu_rd(16'h4305, d); total++; if (d !== 8'hFD) begin bad++; $display("FAIL supp_dasl got=%h exp=FD", d); end
      cpu_rd(16'h4306, d); total++; if (d !== 8'hFF) begin bad++; $display("FAIL supp_dash got=%h exp=FF", d); end
      cpu_rd(16'h4302, d); total++; if (d !== 8'h83) begin bad++; $display("FAIL supp_a1tl got=%h exp=83", d); end
      reset = 1'b1; tick(); reset = 1'b0;
      total++; if (dma_active !== 1'b0) begin bad++; $display("FAIL supp_abort got=%b exp=0", dma_active); end
   endtask

   task automatic test_reset_mid();
      int steps; logic done; logic [7:0] d;
      setup_chan(0, 8'h00, 8'h80, 24'h7E6000, 16'd4);
      cpu_wr(16'h420B, 8'h01);
      run_xfer(4, steps, done);
      total++; if (b_write !== 1'b1 || b_addr !== 8'h80) begin bad++; $display("FAIL rmid_pre got=%b exp=1", b_write); end
      reset = 1'b1;
      tick();
      total++; if (dma_active !== 1'b0) begin bad++; $display("FAIL rmid_active got=%b exp=0", dma_active); end
      total++; if ({a_read, a_write, b_read, b_write} !== 4'b0) begin bad++; $display("FAIL rmid_strobes got=%b exp=0000", {a_read, a_write, b_read, b_write}); end
      total++; if (a_addr !== 24'h0 || b_addr !== 8'h0 || bus_wdata !== 8'h0) begin
         bad++; $display("FAIL rmid_outs got=%h/%h/%h exp=0", a_addr, b_addr, bus_wdata);
      end
      for (int r = 0; r < 7; r++) begin
         cpu_rd(16'h4300 + 16'(r), d);
         total++; if (d !== 8'h00) begin bad++; $display("FAIL rmid_reg r=%0d got=%h exp=00", r, d); end
      end
      reset = 1'b0;
   endtask

   task automatic test_stall();
      int steps; logic done; logic [7:0] d;
      setup_chan(0, 8'h00, 8'h22, 24'h7E7000, 16'd2);
      cpu_wr(16'h420B, 8'h01);
      tick();
      total++; if (a_read !== 1'b1 || a_addr !== 24'h7E7000) begin bad++; $display("FAIL stall_read got=%b %h exp=1 7E7000", a_read, a_addr); end
      cpu_en = 1'b0;
      #1;
      total++; if (a_read !== 1'b0) begin bad++; $display("FAIL stall_gate got=%b exp=0", a_read); end
      tick(); tick();
      total++; if (a_read !== 1'b0 || dma_active !== 1'b1 || a_addr !== 24'h7E7000) begin
         bad++; $display("FAIL stall_hold got=%b %b %h exp=0 1 7E7000", a_read, dma_active, a_addr);
      end
      cpu_en = 1'b1;
      #1;
      total++; if (a_read !== 1'b1) begin bad++; $display("FAIL stall_resume got=%b exp=1", a_read); end
      // Register write attempted mid-transfer must be dropped.
      cpu_wr(16'h4301, 8'h55);
      run_xfer(40, steps, done);
      total++; if (!done || wr_n != 2 || wr_d[0] !== a_src(24'h7E7000)) begin
         bad++; $display("FAIL stall_finish got=%0d %h exp=2 %h", wr_n, wr_d[0], a_src(24'h7E7000));
      end
      cpu_rd(16'h4301, d);
      total++; if (d !== 8'h22) begin bad++; $display("FAIL stall_io_ignored got=%h exp=22", d); end
   endtask

   initial begin
      test_reset();
      test_regs();
      test_basic();
      test_mode1();
      test_mode4_dec();
      test_multi();
      test_b_to_a();
      test_suppress_wrap();
      test_reset_mid();
      test_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
